// File: rtl/rv32i_register_file.sv
// rv32i_register_file -- RV32I integer register file.
//   32 x 32-bit general-purpose registers, x0 hardwired to zero.
//   Two combinational read ports (rs1/rs2), one write port on rising clk_i.
//   Asynchronous active-low reset clears every register immediately.
//   Optional feature macro: REGFILE_BYPASS_EN
//     defined   -> each read port forwards rd_i when it addresses the
//                  register being written in the same cycle.
//     undefined -> reads always reflect the stored register contents.

package rv32i_regfile_pkg;
    localparam int DATA_WIDTH   = 32;
    localparam int NUM_REGISTER = 32;
endpackage

module rv32i_register_file #(
    parameter  int DATA_WIDTH   = rv32i_regfile_pkg::DATA_WIDTH,
    parameter  int NUM_REGISTER = rv32i_regfile_pkg::NUM_REGISTER,
    localparam int AW           = $clog2(NUM_REGISTER)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         rd_addr_i,
    input  logic [DATA_WIDTH-1:0] rd_i,
    input  logic [AW-1:0]         rs1_addr_i,
    input  logic [AW-1:0]         rs2_addr_i,
    output logic [DATA_WIDTH-1:0] rs1_o,
    output logic [DATA_WIDTH-1:0] rs2_o
);

    // Read-side view of every register; entry 0 is the constant zero.
    logic [DATA_WIDTH-1:0] reg_val [NUM_REGISTER];

    assign reg_val[0] = '0;

    // x0 has no storage; x1..x(N-1) each get their own flop bank so the
    // write decode is a simple per-register enable.
    generate
        for (genvar gi = 1; gi < NUM_REGISTER; gi++) begin : g_reg
            logic [DATA_WIDTH-1:0] data_reg;
            logic                  wr_en;

            assign wr_en = we_i && (rd_addr_i == AW'(gi));

            // Async clear dominates; otherwise capture rd_i when selected.
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    data_reg <= '0;
                end else if (wr_en) begin
                    data_reg <= rd_i;
                end
            end

            assign reg_val[gi] = data_reg;
        end
    endgenerate

`ifdef REGFILE_BYPASS_EN
    // A write is forwardable only when it would actually commit at the edge.
    logic wr_fwd;
    assign wr_fwd = we_i && rst_n_i && (rd_addr_i != '0);
`endif

    // Read port 1: combinational lookup, optionally forwarding write data.
    always_comb begin
        rs1_o = reg_val[rs1_addr_i];
`ifdef REGFILE_BYPASS_EN
        if (wr_fwd && (rd_addr_i == rs1_addr_i)) begin
            rs1_o = rd_i;
        end
`endif
    end

    // Read port 2: combinational lookup, optionally forwarding write data.
    always_comb begin
        rs2_o = reg_val[rs2_addr_i];
`ifdef REGFILE_BYPASS_EN
        if (wr_fwd && (rd_addr_i == rs2_addr_i)) begin
            rs2_o = rd_i;
        end
`endif
    end

endmodule

// File: tb/tb_rv32i_register_file.sv
// tb_rv32i_register_file -- scoreboard bench for rv32i_register_file.
// Expected read values come from a bench-side register model and are queued
// when stimulus is applied, then popped and compared against the read ports.

module tb_rv32i_register_file;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          we;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] rs1_addr;
    logic [AW-1:0] rs2_addr;
    logic [DW-1:0] rs1;
    logic [DW-1:0] rs2;

    logic [DW-1:0]   model_q [NR];
    string           tag_q [$];
    logic [2*DW-1:0] exp_q [$];

    int assert_cnt = 0;
    int fail_cnt   = 0;

    always #5 clk = ~clk;

    rv32i_register_file dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .we_i       (we),
        .rd_addr_i  (rd_addr),
        .rd_i       (rd_data),
        .rs1_addr_i (rs1_addr),
        .rs2_addr_i (rs2_addr),
        .rs1_o      (rs1),
        .rs2_o      (rs2)
    );

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        assert_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        return (a == '0) ? '0 : model_q[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NR; i++) model_q[i] = '0;
    endtask

    task automatic sb_push_raw(input string tag, input logic [DW-1:0] e1, input logic [DW-1:0] e2);
        tag_q.push_back(tag);
        exp_q.push_back({e1, e2});
    endtask

    task automatic sb_push(input string tag);
        sb_push_raw(tag, model_rd(rs1_addr), model_rd(rs2_addr));
    endtask

    task automatic sb_pop_check();
        logic [2*DW-1:0] e;
        string           t;
        if (exp_q.size() == 0) begin
            check_val("sb_empty", 32'(exp_q.size()), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        $display("txn %-12s rs1[%0d]=0x%08h rs2[%0d]=0x%08h", t, rs1_addr, rs1, rs2_addr, rs2);
        check_val({t, ".rs1"}, rs1, e[2*DW-1:DW]);
        check_val({t, ".rs2"}, rs2, e[DW-1:0]);
    endtask

    // One clocked transaction: drive at negedge, commit in the model at the
    // rising edge, then compare just after the edge.
    task automatic cycle(input string tag, input logic w, input logic [AW-1:0] rd,
                         input logic [DW-1:0] d, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        @(negedge clk);
        we = w; rd_addr = rd; rd_data = d; rs1_addr = a1; rs2_addr = a2;
        @(posedge clk);
        if (rst_n && w && (rd != '0)) model_q[rd] = d;
        sb_push(tag);
        #1;
        sb_pop_check();
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; rd_addr = '0; rd_data = '0; rs1_addr = '0; rs2_addr = '0;
        model_clear();

        // Outputs read zero while reset is held, whatever the address.
        #12;
        rs1_addr = 5'd31; rs2_addr = 5'd1;
        #1;
        sb_push("in_reset");
        sb_pop_check();
        @(negedge clk);
        rst_n = 1'b1;

        cycle("rst_x0",   1'b0, 5'd0,  32'h0,        5'd0,  5'd0);
        cycle("wr_x1",    1'b1, 5'd1,  32'h00000001, 5'd1,  5'd2);
        cycle("wr_x31",   1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd0);
        cycle("wr_x0",    1'b1, 5'd0,  32'hFFFFFFFF, 5'd31, 5'd0);
        cycle("we0_x5",   1'b0, 5'd5,  32'h12345678, 5'd5,  5'd1);

        // Zero-latency read: change addresses between edges.
        @(negedge clk);
        rs1_addr = 5'd1; rs2_addr = 5'd31;
        #1;
        sb_push("comb_rd");
        sb_pop_check();

        // Mixed random traffic, including x0 targets and same-port reads.
        for (int i = 0; i < 24; i++) begin
            logic [AW-1:0] r;
            r = AW'($urandom_range(0, NR - 1));
            cycle("rand", ($urandom_range(0, 3) != 0), r, $urandom,
                  (i % 3 == 0) ? r : AW'($urandom_range(0, NR - 1)),
                  (i % 4 == 0) ? r : AW'($urandom_range(0, NR - 1)));
        end

        cycle("same_reg", 1'b1, 5'd9, 32'hCAFEF00D, 5'd9, 5'd9);

        // Read-during-write to x7.
        cycle("x7_old", 1'b1, 5'd7, 32'h0BADF00D, 5'd7, 5'd3);
        @(negedge clk);
        we = 1'b1; rd_addr = 5'd7; rd_data = 32'hA5A5A5A5; rs1_addr = 5'd7; rs2_addr = 5'd3;
        #1;
`ifdef REGFILE_BYPASS_EN
        sb_push_raw("rdw_pre", 32'hA5A5A5A5, model_rd(5'd3));
`else
        sb_push("rdw_pre");
`endif
        sb_pop_check();
        @(posedge clk);
        model_q[7] = 32'hA5A5A5A5;
        sb_push("rdw_post");
        #1;
        sb_pop_check();

        // Asynchronous reset between edges, with a write attempted under reset.
        cycle("pre_x1",  1'b1, 5'd1,  32'h11112222, 5'd1, 5'd31);
        cycle("pre_x3",  1'b1, 5'd3,  32'h33334444, 5'd3, 5'd31);
        @(negedge clk);
        we = 1'b0; rs1_addr = 5'd1; rs2_addr = 5'd31;
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        sb_push("async_rst");
        sb_pop_check();
        we = 1'b1; rd_addr = 5'd3; rd_data = 32'hDEADBEEF; rs1_addr = 5'd3; rs2_addr = 5'd1;
        @(posedge clk);
        #1;
        sb_push("wr_in_rst");
        sb_pop_check();
        @(negedge clk);
        we = 1'b0;
        rst_n = 1'b1;
        #1;
        sb_push("post_rst");
        sb_pop_check();

        cycle("after_rst", 1'b1, 5'd3, 32'h5A5A0F0F, 5'd3, 5'd31);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
